// File: rtl/serial_sub_ctrl.sv
// Bit-serial A-B-Bin controller driving one external full subtractor, LSB first.
// Optional zero/ovf result flags are enabled by defining SERIAL_SUB_FLAGS_EN.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             fs_a,
  output logic             fs_b,
  output logic             fs_bin,
  input  logic             fs_d,
  input  logic             fs_bout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             borrow;
  logic             in_run;
  logic             last_bit;
  logic [WIDTH-1:0] result_next;

`ifdef SERIAL_SUB_FLAGS_EN
  // Operand sign bits are captured at load because the shift regs lose them.
  logic a_msb;
  logic b_msb;
`endif

  assign in_run      = (state == ST_RUN);
  assign last_bit    = (count == CW'(WIDTH - 1));
  assign result_next = {fs_d, res_sh[WIDTH-1:1]};

  assign fs_a   = in_run & a_sh[0];
  assign fs_b   = in_run & b_sh[0];
  assign fs_bin = in_run & borrow;
  assign busy   = in_run;
  assign done   = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      count  <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      borrow <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= bin;
            count  <= '0;
`ifdef SERIAL_SUB_FLAGS_EN
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
`endif
            state  <= ST_RUN;
          end else begin
            state  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          res_sh <= result_next;
          borrow <= fs_bout;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          count  <= count + 1'b1;
          if (last_bit) begin
            diff  <= result_next;
            bout  <= fs_bout;
`ifdef SERIAL_SUB_FLAGS_EN
            zero  <= (result_next == '0);
            ovf   <= (a_msb != b_msb) && (fs_d != a_msb);
`endif
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Randomized self-checking bench for serial_sub_ctrl with a behavioural full subtractor,
// a transaction-level reference model, directed literal checks and a WIDTH=4 sweep.
module tb_serial_sub_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, bin;
  logic [W-1:0] a, b, diff;
  logic         fs_a, fs_b, fs_bin, fs_d, fs_bout, busy, done, bout;
  logic [1:0]   fs_t;
`ifdef SERIAL_SUB_FLAGS_EN
  logic         zero, ovf;
`endif

  assign fs_t    = {1'b0, fs_a} - {1'b0, fs_b} - {1'b0, fs_bin};
  assign fs_d    = fs_t[0];
  assign fs_bout = fs_t[1];

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .fs_a(fs_a), .fs_b(fs_b), .fs_bin(fs_bin), .fs_d(fs_d), .fs_bout(fs_bout),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_FLAGS_EN
    , .zero(zero), .ovf(ovf)
`endif
  );

  // Second instance for the exhaustive 4-bit sweep.
  logic         s4, bin4, f4_a, f4_b, f4_bin, f4_d, f4_bout, busy4, done4, bout4;
  logic [3:0]   a4, b4, diff4;
  logic [1:0]   f4_t;
`ifdef SERIAL_SUB_FLAGS_EN
  logic         zero4, ovf4;
`endif
  assign f4_t    = {1'b0, f4_a} - {1'b0, f4_b} - {1'b0, f4_bin};
  assign f4_d    = f4_t[0];
  assign f4_bout = f4_t[1];

  serial_sub_ctrl #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4), .bin(bin4),
    .fs_a(f4_a), .fs_b(f4_b), .fs_bin(f4_bin), .fs_d(f4_d), .fs_bout(f4_bout),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
`ifdef SERIAL_SUB_FLAGS_EN
    , .zero(zero4), .ovf(ovf4)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: an accepted op yields a-b-bin after W busy cycles.
  int           m_left;
  logic         m_done, m_bout, m_bin, m_zero, m_ovf, m_pz, m_po;
  logic [W-1:0] m_diff, m_a, m_b;
  logic [W:0]   m_pend, in_res;

  assign in_res = {1'b0, a} - {1'b0, b} - (W+1)'(bin);

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left <= 0; m_done <= 1'b0; m_diff <= '0; m_bout <= 1'b0;
      m_zero <= 1'b0; m_ovf <= 1'b0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        {m_bout, m_diff} <= m_pend;
        m_zero <= m_pz; m_ovf <= m_po; m_done <= 1'b1;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_pend <= in_res; m_a <= a; m_b <= b; m_bin <= bin; m_left <= W;
        m_pz   <= (in_res[W-1:0] == '0);
        m_po   <= (a[W-1] != b[W-1]) && (in_res[W-1] != a[W-1]);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int i, lo_a, lo_b;
      chk("busy", 64'(busy), 64'(m_left != 0));
      chk("done", 64'(done), 64'(m_done));
      chk("diff", 64'(diff), 64'(m_diff));
      chk("bout", 64'(bout), 64'(m_bout));
      if (m_left != 0) begin
        i    = W - m_left;
        lo_a = int'(m_a) % (1 << i);
        lo_b = int'(m_b) % (1 << i);
        chk("fs_a", 64'(fs_a), 64'(m_a[i]));
        chk("fs_b", 64'(fs_b), 64'(m_b[i]));
        chk("fs_bin", 64'(fs_bin), 64'(lo_a < lo_b + int'(m_bin)));
      end else begin
        chk("fs_idle", 64'({fs_a, fs_b, fs_bin}), 64'(0));
      end
`ifdef SERIAL_SUB_FLAGS_EN
      chk("zero", 64'(zero), 64'(m_zero));
      chk("ovf", 64'(ovf), 64'(m_ovf));
`endif
    end
  end

  // Issue one op from idle; returns cycles from accepting edge to the done cycle.
  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin,
                       output int lat);
    @(negedge clk);
    a = xa; b = xb; bin = xbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!done) chk("done_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    int lat, seen;
    logic [4:0] exp4;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    s4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_diff", 64'({bout, diff}), 64'(0));
    rst_n = 1'b1;

    // Directed literal cases pinning the model.
    do_op(8'd10, 8'd3, 1'b0, lat);
    chk("t1_lat", 64'(lat), 64'(9));
    chk("t1_res", 64'({bout, diff}), 64'({1'b0, 8'd7}));
    do_op(8'd3, 8'd10, 1'b0, lat);
    chk("t2a_res", 64'({bout, diff}), 64'({1'b1, 8'hF9}));
    do_op(8'd0, 8'd0, 1'b1, lat);
    chk("t2b_res", 64'({bout, diff}), 64'({1'b1, 8'hFF}));

    // Start held through RUN; then back-to-back accept from DONE.
    @(negedge clk);
    a = 8'd20; b = 8'd5; bin = 1'b0; start = 1'b1;
    seen = 0;
    do begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      seen++;
    end while (!done && seen < 40);
    chk("t3_res", 64'({bout, diff}), 64'({1'b0, 8'd15}));
    a = 8'd50; b = 8'd8; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("t3_b2b_busy", 64'(busy), 64'(1));
    while (!done && seen < 80) begin @(negedge clk); seen++; end
    chk("t3_res2", 64'({bout, diff}), 64'({1'b0, 8'd42}));

    // Reset during RUN cycle 4.
    @(negedge clk);
    a = 8'd100; b = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t4_rst", 64'({busy, done, bout, diff}), 64'(0));
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin @(negedge clk); if (done) seen++; end
    chk("t4_no_done", 64'(seen), 64'(0));
    do_op(8'd100, 8'd1, 1'b1, lat);
    chk("t4_res", 64'({bout, diff}), 64'({1'b0, 8'd98}));

`ifdef SERIAL_SUB_FLAGS_EN
    do_op(8'h80, 8'h01, 1'b0, lat);
    chk("t6a", 64'({diff, ovf, zero}), 64'({8'h7F, 1'b1, 1'b0}));
    do_op(8'd5, 8'd5, 1'b0, lat);
    chk("t6b", 64'({ovf, zero}), 64'({1'b0, 1'b1}));
`endif

    // Random traffic with occasional resets.
    repeat (1500) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      rst_n = ($urandom_range(0, 249) != 0);
    end
    @(negedge clk);
    start = 1'b0; rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk_en = 1'b0;

    // Exhaustive 4-bit sweep.
    for (int x = 0; x < 512; x++) begin
      @(negedge clk);
      a4 = 4'(x & 15); b4 = 4'((x >> 4) & 15); bin4 = 1'((x >> 8) & 1); s4 = 1'b1;
      exp4 = 5'(int'(a4) - int'(b4) - int'(bin4));
      @(negedge clk);
      s4 = 1'b0;
      seen = 0;
      while (!done4 && seen < 20) begin @(negedge clk); seen++; end
      chk("w4_res", 64'({bout4, diff4}), 64'(exp4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
